// File: rtl/sbox_lane_pipe_if.sv
// Valid/ready bus for the multi-lane S-box pipe.
// The producer/consumer side uses master and the substitution unit uses slave.
interface sbox_lane_pipe_if #(
  parameter int unsigned LANES = 16
) ();
  localparam int unsigned DW = 8 * LANES;

  logic          in_valid;
  logic          in_ready;
  logic          in_inv;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_inv;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_inv, out_data
  );

  modport slave (
    input  in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_inv, out_data
  );
endinterface

// File: rtl/sbox_lane_pipe.sv
// Pipelined multi-lane AES SubBytes / InvSubBytes with elastic valid/ready stages.
// The S-box is computed algebraically: GF(2^8) inverse plus the FIPS-197 affine map.
module sbox_lane_pipe #(
  parameter int unsigned LANES       = 16,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sbox_lane_pipe_if.slave  bus,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);
  localparam int unsigned DW = 8 * LANES;
  localparam int unsigned NS = PIPE_STAGES;

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("sbox_lane_pipe: PIPE_STAGES must be in 1..4");
  end
  if (LANES < 1 || LANES > 32) begin : g_bad_lanes
    $error("sbox_lane_pipe: LANES must be in 1..32");
  end

  typedef struct packed {
    logic          valid;
    logic          inv;
    logic [DW-1:0] data;
  } stage_t;

  stage_t        st [NS];
  logic [NS-1:0] en;
  logic [DW-1:0] sub_data;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  always_comb begin
    sub_data = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sub_data[8*i +: 8] = bus.in_inv ? sbox_inv(bus.in_data[8*i +: 8])
                                      : sbox_fwd(bus.in_data[8*i +: 8]);
    end
  end

  // Stage k may load when it is empty or its content moves on; bubbles collapse.
  always_comb begin
    logic acc;
    en      = '0;
    acc     = bus.out_ready | ~st[NS-1].valid;
    en[NS-1] = acc;
    for (int k = int'(NS) - 2; k >= 0; k--) begin
      acc   = ~st[k].valid | acc;
      en[k] = acc;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < int'(NS); k++) busy = busy | st[k].valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NS); k++) st[k] <= '0;
    end else begin
      if (en[0]) st[0] <= stage_t'{valid: bus.in_valid, inv: bus.in_inv, data: sub_data};
      for (int k = 1; k < int'(NS); k++) begin
        if (en[k]) st[k] <= st[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (st[NS-1].valid && bus.out_ready) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = st[NS-1].valid;
  assign bus.out_inv   = st[NS-1].inv;
  assign bus.out_data  = st[NS-1].data;
endmodule

// File: tb/tb_sbox_lane_pipe.sv
// Scoreboard bench for sbox_lane_pipe: driver pushes expected beats, a monitor pops on delivery.
// The reference S-box is derived from GF(2^8) arithmetic by brute-force inversion.
module tb_sbox_lane_pipe;
  localparam int unsigned LANES = 16;
  localparam int unsigned PS    = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DW    = 8 * LANES;

  typedef struct packed {
    logic          inv;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] beat_cnt;
  logic             busy;

  sbox_lane_pipe_if #(.LANES(LANES)) bus ();

  sbox_lane_pipe #(.LANES(LANES), .PIPE_STAGES(PS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .beat_cnt(beat_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t exp_q[$];
  int deliv_cyc[$];
  logic [DW-1:0] loop_q[$];
  bit capture = 0;
  bit rand_ready = 0;
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (a != 8'h00)
      for (int y = 1; y < 256; y++) if (gmul(a, 8'(y)) == 8'h01) r = 8'(y);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      b[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
    return b;
  endfunction

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(LANES); i++)
      r[8*i +: 8] = inv ? isb[d[8*i +: 8]] : sb[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < int'(LANES); i++) r[8*i +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic logic [DW-1:0] pat(input int x);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(LANES); i++) r[8*i +: 8] = 8'(x + i);
    return r;
  endfunction

  // Returns at posedge+1 after the beat was accepted
  task automatic send(input logic [DW-1:0] d, input logic inv, input logic [DW-1:0] e);
    int n;
    bit done;
    n = 0;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_inv   = inv;
    while (!done && n < 1000) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(exp_t'{inv: inv, data: e});
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout actual=not_accepted required=accepted t=%0t", $time);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
  endtask

  // Random backpressure, applied clear of both clock edges
  always @(posedge clk) begin
    #2;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: delivery check, stall stability, beat counter tracking
  int            dcnt = 0;
  bit            hold_v = 0;
  logic [DW-1:0] hold_d;
  logic          hold_i;
  always @(negedge clk) begin
    if (!rst_n) begin
      dcnt   = 0;
      hold_v = 0;
    end else begin
      chk("beat_cnt", 256'(beat_cnt), 256'(CNT_W'(dcnt)));
      if (hold_v) begin
        chk("stall_valid", 256'(bus.out_valid), 256'(1'b1));
        chk("stall_data", 256'(bus.out_data), 256'(hold_d));
        chk("stall_inv", 256'(bus.out_inv), 256'(hold_i));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat actual=%0h required=none", bus.out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", 256'(bus.out_data), 256'(e.data));
          chk("out_inv", 256'(bus.out_inv), 256'(e.inv));
        end
        dcnt++;
        deliv_cyc.push_back(cyc);
        if (capture) loop_q.push_back(bus.out_data);
        hold_v = 0;
      end else if (bus.out_valid) begin
        hold_v = 1;
        hold_d = bus.out_data;
        hold_i = bus.out_inv;
      end else begin
        hold_v = 0;
      end
    end
  end

  initial begin
    int lat;
    int acc;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    logic inv;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inv    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int x = 0; x < 256; x++) sb[x] = affine(ginv(8'(x)));
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

    #1;
    chk("rst_out_valid", 256'(bus.out_valid), 256'(1'b0));
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_beat_cnt", 256'(beat_cnt), 256'(0));
    chk("rst_in_ready", 256'(bus.in_ready), 256'(1'b1));
    chk("rst_out_data", 256'(bus.out_data), 256'(0));
    chk("rst_out_inv", 256'(bus.out_inv), 256'(1'b0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: forward of zero, latency check
    bus.out_ready = 1'b1;
    send('0, 1'b0, {LANES{8'h63}});
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 256'(lat), 256'(PS - 1));
    wait_drain();

    // T2: inverse spot values, then forward 0x53
    d = {LANES{8'h63}};
    d[7:0] = 8'h63; d[15:8] = 8'h00; d[23:16] = 8'h01;
    e = '0;
    e[15:8] = 8'h52; e[23:16] = 8'h09;
    send(d, 1'b1, e);
    send({LANES{8'h53}}, 1'b0, {LANES{8'hED}});
    wait_drain();

    // T3: alternating direction at full rate
    deliv_cyc.delete();
    for (int i = 0; i < 8; i++)
      send({LANES{8'h01}}, 1'(i % 2), (i % 2) ? {LANES{8'h09}} : {LANES{8'h7C}});
    wait_drain();
    chk("t3_beats", 256'(deliv_cyc.size()), 256'(8));
    if (deliv_cyc.size() == 8)
      chk("t3_rate", 256'(deliv_cyc[7] - deliv_cyc[0]), 256'(7));

    // T4: stall fills exactly PS stages, then releases in order
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < int'(PS) + 3; c++) begin
      d = rand_data();
      inv = 1'(c % 2);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_inv   = inv;
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(exp_t'{inv: inv, data: model(d, inv)});
        acc++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("t4_accepted", 256'(acc), 256'(PS));
    chk("t4_in_ready", 256'(bus.in_ready), 256'(1'b0));
    chk("t4_busy", 256'(busy), 256'(1'b1));
    repeat (3) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    wait_drain();

    // Random traffic with random backpressure and idle gaps
    rand_ready = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      d = rand_data();
      inv = 1'($urandom_range(0, 1));
      send(d, inv, model(d, inv));
    end
    rand_ready = 0;
    @(posedge clk); #3;
    bus.out_ready = 1'b1;
    wait_drain();

    // T6: reset with two beats in flight
    bus.out_ready = 1'b0;
    send(rand_data(), 1'b0, '0);
    send(rand_data(), 1'b1, '0);
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 256'(bus.out_valid), 256'(1'b0));
    chk("t6_busy", 256'(busy), 256'(1'b0));
    chk("t6_beat_cnt", 256'(beat_cnt), 256'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("t6_idle_busy", 256'(busy), 256'(1'b0));

    // T5: exhaustive forward, loop outputs back through inverse
    loop_q.delete();
    capture = 1;
    for (int x = 0; x < 256; x++) send(pat(x), 1'b0, model(pat(x), 1'b0));
    wait_drain();
    capture = 0;
    chk("t5_loop_size", 256'(loop_q.size()), 256'(256));
    for (int x = 0; x < 256 && x < loop_q.size(); x++) send(loop_q[x], 1'b1, pat(x));
    wait_drain();
    chk("t5_beat_cnt", 256'(beat_cnt), 256'(512));
    chk("t5_busy", 256'(busy), 256'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
